// File: rtl/cpu_pkg.sv
// Shared encodings for the parametrised accumulator CPU core: FSM states,
// instruction field values and the ROM/RAM select levels.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_D = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM_A   = 3'd4,
    ST_MEM_D   = 3'd5
  } state_e;

  // ALU sub-opcode, instr[5:3] when instr[7:6] == PFX_ALU
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_MOVA = 3'd5;
  localparam logic [2:0] ALU_MOVR = 3'd6;
  localparam logic [2:0] ALU_CLR  = 3'd7;

  localparam logic [1:0] PFX_ALU = 2'b01;
  localparam logic [2:0] PFX_LDI = 3'b100;
  localparam logic [3:0] PFX_MEM = 4'b1010;
  localparam logic [1:0] PFX_JZ  = 2'b11;

  localparam logic SEL_ROM = 1'b0;
  localparam logic SEL_RAM = 1'b1;

  // Register selector shared by ALU, LD and ST encodings
  function automatic logic [2:0] reg_sel(input logic [7:0] instr);
    return instr[2:0];
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// General register file: one combinational read port, one synchronous write
// port. Indices at or above NREGS read as zero and swallow writes.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int NREGS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      rd_idx,
  output logic [BITS-1:0] rd_data,
  input  logic            wr_en,
  input  logic [2:0]      wr_idx,
  input  logic [BITS-1:0] wr_data
);

  logic [BITS-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] wr_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_sel
      assign wr_sel[gi] = wr_en && (wr_idx == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else if (wr_sel[i]) begin
        regs_q[i] <= wr_data;
      end
    end
  end

  // Decoded read keeps unimplemented indices at zero without indexing past the array
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_idx == 3'(i)) begin
        rd_data = regs_q[i];
      end
    end
  end

endmodule

// File: rtl/cpu_core_p.sv
// Parametrised accumulator CPU core driving one multiplexed address/data bus
// with a valid/ready handshake; FSM, decode and ALU live here.
module cpu_core_p
  import cpu_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int PC_BITS = 8,
  parameter int NREGS   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BITS-1:0]    bus_in,
  input  logic               bus_ready,
  output logic [BITS-1:0]    bus_out,
  output logic               bus_valid,
  output logic               addr_data,
  output logic               rom_ram,
  output logic               bus_we,
  output logic [PC_BITS-1:0] pc_out,
  output logic [BITS-1:0]    acc_out
);

  state_e             state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [BITS-1:0]    acc_q, acc_d;
  logic [7:0]         instr_q, instr_d;

  logic [BITS-1:0]    rf_rd;
  logic               rf_we;
  logic [BITS-1:0]    alu_res;
  logic [BITS-1:0]    pc_ext;
  logic [PC_BITS-1:0] jz_off;
  logic signed [5:0]  jz_imm;
  logic [2:0]         alu_op;
  logic               is_alu, is_ldi, is_mem, is_st, is_jz;

  cpu_regfile #(
    .BITS  (BITS),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (reg_sel(instr_q)),
    .rd_data (rf_rd),
    .wr_en   (rf_we),
    .wr_idx  (reg_sel(instr_q)),
    .wr_data (acc_q)
  );

  assign alu_op = instr_q[5:3];
  assign is_alu = (instr_q[7:6] == PFX_ALU);
  assign is_ldi = (instr_q[7:5] == PFX_LDI);
  assign is_mem = (instr_q[7:4] == PFX_MEM);
  assign is_st  = is_mem && instr_q[3];
  assign is_jz  = (instr_q[7:6] == PFX_JZ);

  // Signed size cast sign-extends the 6-bit branch offset to the PC width
  assign jz_imm = $signed(instr_q[5:0]);
  assign jz_off = PC_BITS'(jz_imm);
  assign pc_ext = BITS'(pc_q);

  assign pc_out  = pc_q;
  assign acc_out = acc_q;

  always_comb begin
    alu_res = acc_q;
    case (alu_op)
      ALU_ADD:  alu_res = acc_q + rf_rd;
      ALU_SUB:  alu_res = acc_q - rf_rd;
      ALU_AND:  alu_res = acc_q & rf_rd;
      ALU_OR:   alu_res = acc_q | rf_rd;
      ALU_XOR:  alu_res = acc_q ^ rf_rd;
      ALU_MOVA: alu_res = rf_rd;
      ALU_MOVR: alu_res = acc_q;
      ALU_CLR:  alu_res = '0;
      default:  alu_res = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      pc_q    <= '0;
      acc_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      instr_q <= instr_d;
    end
  end

  // Bus outputs depend only on state and stable registers, so they hold
  // steady for as long as the target keeps bus_ready low.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    instr_d   = instr_q;
    rf_we     = 1'b0;
    bus_valid = 1'b0;
    addr_data = 1'b1;
    rom_ram   = SEL_ROM;
    bus_we    = 1'b0;
    bus_out   = '0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH_A;
      end

      ST_FETCH_A: begin
        bus_valid = 1'b1;
        bus_out   = pc_ext;
        if (bus_ready) begin
          state_d = ST_FETCH_D;
        end
      end

      ST_FETCH_D: begin
        bus_valid = 1'b1;
        addr_data = 1'b0;
        bus_out   = pc_ext;
        if (bus_ready) begin
          instr_d = bus_in[7:0];
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        pc_d    = pc_q + PC_BITS'(1);
        state_d = ST_FETCH_A;
        if (is_alu) begin
          if (alu_op == ALU_MOVR) begin
            rf_we = 1'b1;
          end else begin
            acc_d = alu_res;
          end
        end else if (is_ldi) begin
          acc_d = BITS'(instr_q[4:0]);
        end else if (is_mem) begin
          state_d = ST_MEM_A;
        end else if (is_jz && (acc_q == '0)) begin
          pc_d = pc_q + jz_off;
        end
      end

      ST_MEM_A: begin
        bus_valid = 1'b1;
        rom_ram   = SEL_RAM;
        bus_out   = rf_rd;
        if (bus_ready) begin
          state_d = ST_MEM_D;
        end
      end

      ST_MEM_D: begin
        bus_valid = 1'b1;
        addr_data = 1'b0;
        rom_ram   = SEL_RAM;
        if (is_st) begin
          bus_we  = 1'b1;
          bus_out = acc_q;
        end else begin
          bus_out = rf_rd;
        end
        if (bus_ready) begin
          if (!is_st) begin
            acc_d = bus_in;
          end
          state_d = ST_FETCH_A;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_core_p.sv
// Self-checking bench for cpu_core_p: a ROM/RAM bus model, a scoreboard of
// expected fetch/store events, a program table and hand-written corner cases.
module tb_cpu_core_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       reset, bus_ready;
  logic [7:0] bus_in, bus_out, pc_out, acc_out;
  logic       bus_valid, addr_data, rom_ram, bus_we;

  // 16-bit, 4-register instance
  logic        reset16;
  logic        bus_ready16 = 1'b1;
  logic [15:0] bus_in16, bus_out16, acc_out16;
  logic [7:0]  pc_out16;
  logic        bus_valid16, addr_data16, rom_ram16, bus_we16;

  cpu_core_p #(.BITS(8), .PC_BITS(8), .NREGS(8)) u_dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_ready(bus_ready),
    .bus_out(bus_out), .bus_valid(bus_valid), .addr_data(addr_data),
    .rom_ram(rom_ram), .bus_we(bus_we), .pc_out(pc_out), .acc_out(acc_out)
  );

  cpu_core_p #(.BITS(16), .PC_BITS(8), .NREGS(4)) u_dut16 (
    .clk(clk), .reset(reset16), .bus_in(bus_in16), .bus_ready(bus_ready16),
    .bus_out(bus_out16), .bus_valid(bus_valid16), .addr_data(addr_data16),
    .rom_ram(rom_ram16), .bus_we(bus_we16), .pc_out(pc_out16), .acc_out(acc_out16)
  );

  // Bus model: latch the address phase, answer the data phase from ROM or RAM.
  // RAM is read-only backing; stores are checked by the scoreboard instead.
  logic [7:0] rom   [256];
  logic [7:0] ram   [256];
  logic [7:0] rom16 [256];
  logic [7:0] addr_lat, addr16_lat;

  always_ff @(posedge clk) begin
    if (bus_valid && bus_ready && addr_data) addr_lat <= bus_out;
    if (bus_valid16 && bus_ready16 && addr_data16) addr16_lat <= bus_out16[7:0];
  end

  always_comb begin
    bus_in   = rom_ram ? ram[addr_lat] : rom[addr_lat];
    // Upper ROM bits set so the core must ignore them when latching instr
    bus_in16 = rom_ram16 ? 16'hA5A5 : {8'hFF, rom16[addr16_lat]};
  end

  typedef struct packed {
    logic        is_st;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  typedef struct {
    logic [7:0] op;
    logic [7:0] pc;
    logic [7:0] acc;
    logic       st;
    logic [7:0] st_a;
    logic [7:0] st_d;
  } vec_t;

  exp_t q8[$];
  exp_t q16[$];
  vec_t vecs[21];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic push8(input logic st, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.is_st = st;
    e.a = a;
    e.b = b;
    q8.push_back(e);
  endtask

  task automatic push16(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.is_st = 1'b0;
    e.a = a;
    e.b = b;
    q16.push_back(e);
  endtask

  // Sampled 1 time unit after the falling edge, once the driver's inputs settled
  task automatic mon8();
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && bus_valid && bus_ready && q8.size() > 0) begin
        if (addr_data && !rom_ram) begin
          e = q8.pop_front();
          chk("fetch8 {bus_out,pc,acc,we,st}", {bus_out, pc_out, acc_out, bus_we, e.is_st},
              {e.a[7:0], e.a[7:0], e.b[7:0], 1'b0, 1'b0});
        end else if (!addr_data && rom_ram && bus_we) begin
          e = q8.pop_front();
          chk("store8 {addr,data,st}", {addr_lat, bus_out, e.is_st}, {e.a[7:0], e.b[7:0], 1'b1});
        end
      end
    end
  endtask

  task automatic mon16();
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset16 && bus_valid16 && bus_ready16 && addr_data16 && !rom_ram16 && q16.size() > 0) begin
        e = q16.pop_front();
        chk("fetch16 {bus_out,pc,acc,we}", {bus_out16, pc_out16, acc_out16, bus_we16},
            {e.a, e.a[7:0], e.b, 1'b0});
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    bus_ready = 1'b1;
    q8.delete();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    @(negedge clk);
    chk("reset {pc,acc,out,valid,ad,rr,we}",
        {pc_out, acc_out, bus_out, bus_valid, addr_data, rom_ram, bus_we},
        {8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic drain(input bit wide, input int budget);
    int left;
    for (int i = 0; i < budget; i++) begin
      left = wide ? q16.size() : q8.size();
      if (left == 0) break;
      @(negedge clk);
    end
    left = wide ? q16.size() : q8.size();
    chk(wide ? "drain16 pending" : "drain8 pending", 48'(left), 48'd0);
    if (wide) q16.delete(); else q8.delete();
  endtask

  initial begin
    int         n;
    bit         found;
    logic [10:0] snap;

    reset   = 1'b1;
    reset16 = 1'b1;
    bus_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rom[i]   = 8'h00;
      ram[i]   = 8'h00;
      rom16[i] = 8'h00;
    end
    ram[5] = 8'h3C;

    fork
      mon8();
      mon16();
    join_none

    // {opcode, pc after, acc after, store?, store addr, store data}
    vecs[0]  = '{8'h85, 8'd1,  8'h05, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{8'h71, 8'd2,  8'h05, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{8'h83, 8'd3,  8'h03, 1'b0, 8'h00, 8'h00};
    vecs[3]  = '{8'h41, 8'd4,  8'h08, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{8'hA9, 8'd5,  8'h08, 1'b1, 8'h05, 8'h08};
    vecs[5]  = '{8'hA1, 8'd6,  8'h3C, 1'b0, 8'h00, 8'h00};
    vecs[6]  = '{8'h72, 8'd7,  8'h3C, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{8'h8F, 8'd8,  8'h0F, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{8'h4A, 8'd9,  8'hD3, 1'b0, 8'h00, 8'h00};
    vecs[9]  = '{8'h52, 8'd10, 8'h10, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{8'h59, 8'd11, 8'h15, 1'b0, 8'h00, 8'h00};
    vecs[11] = '{8'h62, 8'd12, 8'h29, 1'b0, 8'h00, 8'h00};
    vecs[12] = '{8'h69, 8'd13, 8'h05, 1'b0, 8'h00, 8'h00};
    vecs[13] = '{8'h7F, 8'd14, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[14] = '{8'h00, 8'd15, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[15] = '{8'h3A, 8'd16, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[16] = '{8'hB5, 8'd17, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[17] = '{8'hC3, 8'd20, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[18] = '{8'h81, 8'd21, 8'h01, 1'b0, 8'h00, 8'h00};
    vecs[19] = '{8'hFE, 8'd22, 8'h01, 1'b0, 8'h00, 8'h00};
    vecs[20] = '{8'hAA, 8'd23, 8'h01, 1'b1, 8'h3C, 8'h01};

    // Table-driven program; each opcode sits at the pc the previous one leaves
    do_reset();
    push8(1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 21; i++) begin
      rom[(i == 0) ? 8'd0 : vecs[i-1].pc] = vecs[i].op;
      if (vecs[i].st) push8(1'b1, 16'(vecs[i].st_a), 16'(vecs[i].st_d));
      push8(1'b0, 16'(vecs[i].pc), 16'(vecs[i].acc));
    end
    reset = 1'b0;
    drain(1'b0, 400);

    // Wait states: 3 stalled cycles in FETCH_D
    do_reset();
    rom[0] = 8'h85;
    push8(1'b0, 16'd0, 16'd0);
    push8(1'b0, 16'd1, 16'h05);
    reset = 1'b0;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (bus_valid && !addr_data && !rom_ram) begin
        found = 1'b1;
        break;
      end
    end
    chk("fetch_d reached", 48'(found), 48'd1);
    snap = {bus_out, addr_data, rom_ram, bus_we};
    bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n++;
      chk("wait hold {out,ad,rr,we,valid}", {bus_out, addr_data, rom_ram, bus_we, bus_valid}, {snap, 1'b1});
    end
    bus_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (acc_out == 8'h05) break;
      @(negedge clk);
      n++;
    end
    chk("wait latency edges", 48'(n), 48'd7);
    drain(1'b0, 40);

    // JZ -2 at pc=6, acc=0: taken back to 4
    do_reset();
    rom[6] = 8'hFE;
    for (int i = 0; i <= 6; i++) push8(1'b0, 16'(i), 16'd0);
    push8(1'b0, 16'd4, 16'd0);
    reset = 1'b0;
    drain(1'b0, 60);

    // JZ -2 at pc=6, acc=1: falls through to 7
    do_reset();
    rom[0] = 8'h81;
    rom[6] = 8'hFE;
    push8(1'b0, 16'd0, 16'd0);
    for (int i = 1; i <= 7; i++) push8(1'b0, 16'(i), 16'd1);
    reset = 1'b0;
    drain(1'b0, 60);

    // JZ -2 at pc=0 wraps to 254
    do_reset();
    rom[0] = 8'hFE;
    push8(1'b0, 16'd0, 16'd0);
    push8(1'b0, 16'd254, 16'd0);
    reset = 1'b0;
    drain(1'b0, 20);

    // Reset during the ST data phase drops the write
    do_reset();
    rom[0] = 8'h85;
    rom[1] = 8'hA8;
    push8(1'b0, 16'd0, 16'd0);
    push8(1'b0, 16'd1, 16'h05);
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_valid && !addr_data && rom_ram && bus_we) begin
        found = 1'b1;
        break;
      end
    end
    chk("st data phase reached {found,out}", {found, bus_out}, {1'b1, 8'h05});
    reset = 1'b1;
    @(negedge clk);
    chk("abort st {valid,we,pc,acc}", {bus_valid, bus_we, pc_out, acc_out}, {1'b0, 1'b0, 8'h00, 8'h00});
    q8.delete();

    // 16-bit core with 4 registers: r5 is absent, ADD wraps at 2^16
    rom16[0]  = 8'h85; rom16[1] = 8'h75; rom16[2] = 8'h6D; rom16[3] = 8'h85;
    rom16[4]  = 8'h69; rom16[5] = 8'h81; rom16[6] = 8'h70; rom16[7] = 8'h7F;
    rom16[8]  = 8'h48; rom16[9] = 8'h40;
    push16(16'd0,  16'h0000);
    push16(16'd1,  16'h0005);
    push16(16'd2,  16'h0005);
    push16(16'd3,  16'h0000);
    push16(16'd4,  16'h0005);
    push16(16'd5,  16'h0000);
    push16(16'd6,  16'h0001);
    push16(16'd7,  16'h0001);
    push16(16'd8,  16'h0000);
    push16(16'd9,  16'hFFFF);
    push16(16'd10, 16'h0000);
    @(negedge clk);
    reset16 = 1'b0;
    drain(1'b1, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_core_p.md
Name: cpu_core_p

Overview:
Parametrised successor to the 8-bit accumulator CPU core. It uses a configurable data width, PC width and register count, and a writable register file. Memory is reached over one multiplexed address/data bus with a valid/ready handshake, so ROM/RAM wait states are supported. Sits at the top of the CPU tile, driving the shared external bus.

Parameters:
BITS, 8, datapath/accumulator/bus width; legal range 8..32.
PC_BITS, 8, program counter width; must be <= BITS.
NREGS, 8, implemented general registers; legal range 1..8.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
bus_in  input  BITS  read data from ROM/RAM
bus_ready  input  1  target accepts current phase
bus_out  output  BITS  address (address phase) or write data (data phase)
bus_valid  output  1  phase request
addr_data  output  1  1 = address phase, 0 = data phase
rom_ram  output  1  0 = ROM (fetch), 1 = RAM (LD/ST)
bus_we  output  1  1 = write data phase (ST only)
pc_out  output  PC_BITS  current PC (debug)
acc_out  output  BITS  current accumulator (debug)

Behaviour:
- Reset, asserted on any cycle including mid-transaction:
  - Next edge sets pc=0, acc=0, all regs=0, state=RESET.
  - Outputs become bus_valid=0, addr_data=1, rom_ram=0, bus_we=0, bus_out=0.
  - An aborted bus phase is simply dropped.
- FSM states: RESET, FETCH_A, FETCH_D, EXEC, MEM_A, MEM_D.
  - RESET always goes to FETCH_A.
- Handshake:
  - A phase completes on the edge where bus_valid && bus_ready.
  - While waiting, bus_out, addr_data, rom_ram and bus_we are held stable.
  - bus_valid deasserts in EXEC.
- FETCH_A: drive bus_out = zero-extended pc, rom_ram=0, addr_data=1.
- FETCH_D: addr_data=0; on completion latch instr = bus_in[7:0] (upper bits ignored).
- EXEC: 1 cycle; acts on instr as follows.
  - 00000000 NOP.
  - 01 ooo rrr ALU with register r:
    - ADD: acc = acc + r
    - SUB: acc = acc - r
    - AND, OR, XOR: acc = acc op r
    - MOVA: acc = r
    - MOVR: r = acc
    - CLR: acc = 0
    - ooo encodes these in order 0..7.
  - 100 iiiii LDI: acc = zero-extended imm5.
  - 1010 0rrr LD: goes to MEM_A.
  - 1010 1rrr ST: goes to MEM_A.
  - 11 iiiiii JZ: if acc==0, pc = pc + sign-extended imm6; else pc = pc + 1.
  - Other 00xxxxxx and 1011xxxx encodings execute as NOP.
- Arithmetic: modulo 2^BITS with no carry output; pc wraps modulo 2^PC_BITS.
- PC update: pc increments by 1 at EXEC for every instruction except a taken JZ.
- MEM_A: bus_out = reg r, rom_ram=1, addr_data=1.
- MEM_D: addr_data=0.
  - LD: acc = bus_in on completion.
  - ST: bus_out = acc, bus_we=1.
- Register index >= NREGS: reads return 0; writes are ignored.
- Latency with bus_ready tied high: 3 cycles for non-memory instructions, 5 for LD/ST.

Decomposition:
- Package cpu_pkg holds:
  - state encoding constants
  - opcode field constants: ALU_ADD..ALU_CLR, PFX_ALU, PFX_LDI, PFX_MEM, PFX_JZ
  - ROM/RAM select constants
- Sub-module cpu_regfile (BITS, NREGS) provides:
  - 1 combinational read port
  - 1 synchronous write port with enable
  - synchronous reset to 0
- FSM, decode and ALU stay in cpu_core_p.

Test Plan:
- Reset -> after 1 edge: pc_out=0, acc_out=0, bus_valid=0, addr_data=1, rom_ram=0.
- Then first FETCH_A drives bus_out=0.
- bus_ready=1, ROM = 0x85, 0x71, 0x83, 0x41 -> after 12 cycles: acc=8, r1=5, pc=4.
- Continue with ST r1 (0xA9):
  - Address phase: bus_out=5, rom_ram=1, addr_data=1.
  - Data phase: bus_out=8, bus_we=1.
- LD r1 (0xA1) with RAM returning 0x3C -> acc=0x3C.
- Wait states: hold bus_ready=0 for 3 cycles in FETCH_D -> outputs stable, instruction completes 3 cycles late.
- JZ -2 (0xFE) at pc=6:
  - acc=0 -> pc=4.
  - acc=1 -> pc=7.
  - pc=0 with acc=0 -> pc=254, modulo 2^PC_BITS wrap at PC_BITS=8.
- Assert reset during MEM_D of ST -> next edge bus_valid=0, bus_we=0, pc=0.
- BITS=16, NREGS=4: MOVR r5 (0x75) is ignored; MOVA r5 (0x6D) gives acc=0; ADD 0xFFFF+1 wraps to 0.
